bk_pipelined_subtractor: RTL and testbench

BK_PIPELINED_SUBTRACTOR -- requirements
Module: bk_pipelined_subtractor

---
 rtl/bk_pipelined_subtractor.sv | 144 ++++++++++++++
 tb/tb_bk_pipelined_subtractor.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bk_pipelined_subtractor.sv
// Three-stage pipelined subtractor: A - B = A + ~B + 1 with carries resolved by a Brent-Kung tree.
// Up-sweep and down-sweep live in separate stages; one global enable freezes the pipe on stall.
module bk_pipelined_subtractor #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] DIFF,
    output logic             BORROW,
    output logic             OVF,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int unsigned LEVELS = $clog2(WIDTH);

    if ((WIDTH < 4) || (WIDTH > 64) || ((WIDTH & (WIDTH - 1)) != 0)) begin : g_width_check
        $error("bk_pipelined_subtractor: WIDTH must be a power of 2 in 4..64");
    end

    // Stage registers
    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_g;
    logic [WIDTH-1:0] r_s1_p;
    logic             r_s2_valid;
    logic [WIDTH-1:0] r_s2_g;
    logic [WIDTH-1:0] r_s2_p;
    logic [WIDTH-1:0] r_s2_sum_p;
    logic             r_s3_valid;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;
    logic             r_ovf;

    // Combinational nets
    logic             w_stall;
    logic             w_adv;
    logic [WIDTH-1:0] w_g;
    logic [WIDTH-1:0] w_p;
    logic [WIDTH-1:0] w_s1_g;
    logic [WIDTH-1:0] w_up_g;
    logic [WIDTH-1:0] w_up_p;
    logic [WIDTH:0]   w_c;
    logic [WIDTH-1:0] w_diff;
    logic             w_borrow;
    logic             w_ovf;

    assign w_stall  = r_s3_valid & ~out_ready;
    assign w_adv    = ~w_stall;
    assign in_ready = w_adv;

    assign w_g = A & ~B;
    assign w_p = A ^ ~B;
    // Fold the constant carry-in into bit 0 so every prefix G is directly a carry.
    assign w_s1_g = {w_g[WIDTH-1:1], w_g[0] | w_p[0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_g     <= '0;
            r_s1_p     <= '0;
        end else if (w_adv) begin
            r_s1_valid <= in_valid;
            r_s1_g     <= w_s1_g;
            r_s1_p     <= w_p;
        end
    end

    // Up-sweep: node i combines with i-2^l whenever i+1 is a multiple of 2^(l+1).
    always_comb begin
        logic [WIDTH-1:0] v_g;
        logic [WIDTH-1:0] v_p;
        v_g = r_s1_g;
        v_p = r_s1_p;
        for (int l = 0; l < int'(LEVELS); l++) begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                if (((i + 1) % (2 ** (l + 1))) == 0) begin
                    v_g[i] = v_g[i] | (v_p[i] & v_g[i - (2 ** l)]);
                    v_p[i] = v_p[i] & v_p[i - (2 ** l)];
                end
            end
        end
        w_up_g = v_g;
        w_up_p = v_p;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_g     <= '0;
            r_s2_p     <= '0;
            r_s2_sum_p <= '0;
        end else if (w_adv) begin
            r_s2_valid <= r_s1_valid;
            r_s2_g     <= w_up_g;
            r_s2_p     <= w_up_p;
            r_s2_sum_p <= r_s1_p;
        end
    end

    // Down-sweep fills the remaining prefixes; afterwards node i holds G[i:0] = c[i+1].
    always_comb begin
        logic [WIDTH-1:0] v_g;
        logic [WIDTH-1:0] v_p;
        v_g = r_s2_g;
        v_p = r_s2_p;
        for (int l = int'(LEVELS) - 2; l >= 0; l--) begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                if ((((i + 1) % (2 ** (l + 1))) == (2 ** l)) && (i >= (2 ** (l + 1)))) begin
                    v_g[i] = v_g[i] | (v_p[i] & v_g[i - (2 ** l)]);
                    v_p[i] = v_p[i] & v_p[i - (2 ** l)];
                end
            end
        end
        w_c = {v_g, 1'b1};
    end

    assign w_diff   = r_s2_sum_p ^ w_c[WIDTH-1:0];
    assign w_borrow = ~w_c[WIDTH];
    assign w_ovf    = w_c[WIDTH] ^ w_c[WIDTH-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s3_valid <= 1'b0;
            r_diff     <= '0;
            r_borrow   <= 1'b0;
            r_ovf      <= 1'b0;
        end else if (w_adv) begin
            r_s3_valid <= r_s2_valid;
            r_diff     <= w_diff;
            r_borrow   <= w_borrow;
            r_ovf      <= w_ovf;
        end
    end

    assign out_valid = r_s3_valid;
    assign DIFF      = r_diff;
    assign BORROW    = r_borrow;
    assign OVF       = r_ovf;

endmodule

// File: tb/tb_bk_pipelined_subtractor.sv
// Scoreboard bench for bk_pipelined_subtractor: expectations queued on accept, checked on drain.
module tb_bk_pipelined_subtractor;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] DIFF;
    logic         BORROW;
    logic         OVF;
    logic         out_valid;
    logic         out_ready = 1'b0;

    logic [W+1:0] got_v;
    logic [W+1:0] exp_v;
    logic [W+1:0] q[$];

    int n_cmp = 0;
    int n_bad = 0;

    logic [W-1:0] wrap_a [4] = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF};
    logic [W-1:0] wrap_b [4] = '{16'h0001, 16'hFFFF, 16'h0001, 16'hFFFF};
    logic [W+1:0] wrap_e [4] = '{{16'hFFFF, 1'b1, 1'b0}, {16'h0000, 1'b0, 1'b0},
                                 {16'h7FFF, 1'b0, 1'b1}, {16'h8000, 1'b1, 1'b1}};

    assign got_v = {DIFF, BORROW, OVF};

    always #5 clk = ~clk;

    bk_pipelined_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .A         (A),
        .B         (B),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .DIFF      (DIFF),
        .BORROW    (BORROW),
        .OVF       (OVF),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // Reference: {A-B, unsigned borrow, signed overflow}
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] d;
        d = a - b;
        return {d, a < b, (a[W-1] != b[W-1]) && (d[W-1] != a[W-1])};
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h8000;
            3:       return 16'h7FFF;
            default: return W'($urandom);
        endcase
    endfunction

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        n_cmp++;
        if (got_v !== '0) begin
            n_bad++; $display("FAIL reset_outputs: got %h want 0", got_v);
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_basic;
        q.delete();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            in_valid = (k == 0); A = 16'h0005; B = 16'h0003; out_ready = 1'b1;
            #2;
            if (in_valid && in_ready) q.push_back({16'h0002, 1'b0, 1'b0});
            n_cmp++;
            if (out_valid !== (k == 3)) begin
                n_bad++;
                $display("FAIL basic_latency: cycle %0d out_valid got %b want %b", k, out_valid,
                         (k == 3));
            end
            if (out_valid && out_ready) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_bad++; $display("FAIL basic_result: got %h want <none>", got_v);
                end else begin
                    exp_v = q.pop_front();
                    if (got_v !== exp_v) begin
                        n_bad++; $display("FAIL basic_result: got %h want %h", got_v, exp_v);
                    end
                end
            end
        end
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++; $display("FAIL basic_drain: got %0d pending want 0", q.size());
        end
    endtask

    task automatic test_wrap;
        int idx;
        int n_out;
        idx = 0; n_out = 0;
        q.delete();
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            in_valid = (idx < 4); out_ready = 1'b1;
            A = wrap_a[(idx < 4) ? idx : 3];
            B = wrap_b[(idx < 4) ? idx : 3];
            #2;
            if (in_valid && in_ready) begin
                q.push_back(wrap_e[idx]); idx++;
            end
            if (out_valid && out_ready) begin
                n_cmp++; n_out++;
                if (q.size() == 0) begin
                    n_bad++; $display("FAIL wrap_result: got %h want <none>", got_v);
                end else begin
                    exp_v = q.pop_front();
                    if (got_v !== exp_v) begin
                        n_bad++; $display("FAIL wrap_result: got %h want %h", got_v, exp_v);
                    end
                end
            end
        end
        n_cmp++;
        if (n_out != 4) begin
            n_bad++; $display("FAIL wrap_count: got %0d want 4", n_out);
        end
    endtask

    task automatic test_back_to_back;
        int           idx;
        int           n_out;
        int           stall_left;
        logic         seen;
        logic         prev_stall;
        logic [W+1:0] snap;
        idx = 0; n_out = 0; stall_left = 0; seen = 1'b0; prev_stall = 1'b0; snap = '0;
        q.delete();
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            in_valid = (idx < 4); out_ready = 1'b1;
            A = W'((idx + 1) * 10); B = W'(idx + 1);
            #1;
            if (out_valid && !seen) begin
                seen = 1'b1; stall_left = 2;
            end
            if (stall_left > 0) begin
                // Scramble operands while blocked; none of this may be captured.
                out_ready = 1'b0; A = W'($urandom); B = W'($urandom); stall_left--;
            end
            #1;
            if (prev_stall) begin
                n_cmp++;
                if ({out_valid, got_v} !== {1'b1, snap}) begin
                    n_bad++;
                    $display("FAIL b2b_hold: got %b/%h want 1/%h", out_valid, got_v, snap);
                end
            end
            if (!out_ready) begin
                n_cmp++;
                if (in_ready !== 1'b0) begin
                    n_bad++; $display("FAIL b2b_in_ready: got %b want 0", in_ready);
                end
            end
            prev_stall = out_valid && !out_ready;
            snap = got_v;
            if (in_valid && in_ready) begin
                q.push_back(model(A, B)); idx++;
            end
            if (out_valid && out_ready) begin
                n_cmp++; n_out++;
                if (q.size() == 0) begin
                    n_bad++; $display("FAIL b2b_result: got %h want <none>", got_v);
                end else begin
                    exp_v = q.pop_front();
                    if ((got_v !== exp_v) || (DIFF !== W'(9 * n_out))) begin
                        n_bad++;
                        $display("FAIL b2b_result: got %h want %h (diff %0d)", got_v, exp_v,
                                 9 * n_out);
                    end
                end
            end
        end
        n_cmp++;
        if ((n_out != 4) || (idx != 4) || (q.size() != 0)) begin
            n_bad++;
            $display("FAIL b2b_count: got out=%0d in=%0d pending=%0d want 4/4/0", n_out, idx,
                     q.size());
        end
    endtask

    task automatic test_reset_midflight;
        q.delete();
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            out_ready = 1'b1; in_valid = 1'b0;
            case (k)
                0: begin in_valid = 1'b1; A = 16'h0050; B = 16'h0010; end
                1: begin in_valid = 1'b1; A = 16'h0060; B = 16'h0020; end
                2: rst = 1'b1;
                3: begin rst = 1'b0; in_valid = 1'b1; A = 16'h0100; B = 16'h0001; end
                default: ;
            endcase
            #2;
            if (rst) begin
                n_cmp++;
                if ({out_valid, got_v, in_ready} !== {1'b0, {(W + 2){1'b0}}, 1'b1}) begin
                    n_bad++;
                    $display("FAIL midrst_state: got v=%b out=%h rdy=%b want 0/0/1", out_valid,
                             got_v, in_ready);
                end
                q.delete();
            end else if (in_valid && in_ready) begin
                q.push_back(model(A, B));
            end
            n_cmp++;
            if (out_valid !== (k == 6)) begin
                n_bad++;
                $display("FAIL midrst_valid: cycle %0d got %b want %b", k, out_valid, (k == 6));
            end
            if (out_valid && out_ready) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_bad++; $display("FAIL midrst_result: got %h want <none>", got_v);
                end else begin
                    exp_v = q.pop_front();
                    if ((got_v !== exp_v) || (DIFF !== 16'h00FF)) begin
                        n_bad++; $display("FAIL midrst_result: got %h want %h", got_v, exp_v);
                    end
                end
            end
        end
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++; $display("FAIL midrst_drain: got %0d pending want 0", q.size());
        end
    endtask

    task automatic test_random;
        int           sent;
        int           got;
        int           cyc;
        logic         prev_stall;
        logic [W+2:0] snap;
        sent = 0; got = 0; cyc = 0; prev_stall = 1'b0; snap = '0;
        q.delete();
        while ((got < 10000) && (cyc < 60000)) begin
            cyc++;
            @(negedge clk);
            in_valid  = (sent < 10000) && ($urandom_range(0, 3) != 0);
            A         = pick();
            B         = pick();
            out_ready = ($urandom_range(0, 3) != 0);
            #2;
            if (prev_stall) begin
                n_cmp++;
                if ({out_valid, got_v} !== snap) begin
                    n_bad++; $display("FAIL rand_hold: got %h want %h", {out_valid, got_v}, snap);
                end
            end
            n_cmp++;
            if (in_ready !== !(out_valid && !out_ready)) begin
                n_bad++;
                $display("FAIL rand_in_ready: got %b want %b", in_ready,
                         !(out_valid && !out_ready));
            end
            prev_stall = out_valid && !out_ready;
            snap = {out_valid, got_v};
            if (in_valid && in_ready) begin
                q.push_back(model(A, B)); sent++;
            end
            if (out_valid && out_ready) begin
                n_cmp++; got++;
                if (q.size() == 0) begin
                    n_bad++; $display("FAIL rand_result: got %h want <none>", got_v);
                end else begin
                    exp_v = q.pop_front();
                    if (got_v !== exp_v) begin
                        n_bad++; $display("FAIL rand_result: got %h want %h", got_v, exp_v);
                    end
                end
            end
        end
        n_cmp++;
        if ((got != 10000) || (q.size() != 0)) begin
            n_bad++;
            $display("FAIL rand_count: got %0d results %0d pending want 10000/0", got, q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_back_to_back();
        test_reset_midflight();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
